// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_BITS data (LSB first), optional parity, 1/2 stop.
// Define UART_TX_BREAK_EN to add the tx_break input that holds the line low while idle.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_dv,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                 tx_break,
`endif
    output logic                 tx_active,
    output logic                 tx_data_out,
    output logic                 tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]           state;
    logic [CW-1:0]        baud_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 par_en;
    logic                 two_stop;
    logic                 stop_second;
    logic                 brk_q;
    logic                 bit_end;
    logic                 accept;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign tx_ready = (state == IDLE) && !rst && !brk_q;
    assign accept   = tx_dv && tx_ready;

`ifndef UART_TX_BREAK_EN
    assign brk_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            par_en      <= 1'b0;
            two_stop    <= 1'b0;
            stop_second <= 1'b0;
            tx_data_out <= 1'b1;
            tx_active   <= 1'b0;
            tx_done     <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_q       <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    baud_cnt    <= '0;
                    bit_idx     <= '0;
                    stop_second <= 1'b0;
                    if (accept) begin
                        // Frame config is frozen here; later cfg changes wait for the next word.
                        shreg       <= tx_data_in;
                        par_bit     <= (^tx_data_in) ^ cfg_parity[1];
                        par_en      <= ^cfg_parity;
                        two_stop    <= cfg_two_stop;
                        tx_data_out <= 1'b0;
                        tx_active   <= 1'b1;
                        state       <= START;
                    end else begin
`ifdef UART_TX_BREAK_EN
                        brk_q       <= tx_break;
                        tx_data_out <= !tx_break;
                        tx_active   <= tx_break;
`else
                        tx_data_out <= 1'b1;
                        tx_active   <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt    <= '0;
                        tx_data_out <= shreg[0];
                        shreg       <= shreg >> 1;
                        state       <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            if (par_en) begin
                                tx_data_out <= par_bit;
                                state       <= PARITY;
                            end else begin
                                tx_data_out <= 1'b1;
                                state       <= STOP;
                            end
                        end else begin
                            bit_idx     <= bit_idx + IW'(1);
                            tx_data_out <= shreg[0];
                            shreg       <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt    <= '0;
                        tx_data_out <= 1'b1;
                        state       <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (two_stop && !stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            stop_second <= 1'b0;
                            tx_done     <= 1'b1;
                            tx_active   <= 1'b0;
                            tx_data_out <= 1'b1;
                            state       <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8-bit and 7-bit instances at 4 clocks per bit.
// Break-mode scenarios compile only when UART_TX_BREAK_EN is defined.
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst;
    logic       dv8, ready8, active8, line8, done8, two8;
    logic [7:0] data8;
    logic [1:0] par8;
    logic       dv7, ready7, active7, line7, done7, two7;
    logic [6:0] data7;
    logic [1:0] par7;
    logic       brk8, brk7;
    int         checks;
    int         errors;

    localparam logic [7:0] PV_DATA [5] = '{8'hA5, 8'hA5, 8'h01, 8'h01, 8'hA5};
    localparam logic [1:0] PV_MODE [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b11};
    localparam logic       PV_BIT  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam int         PV_LEN  [5] = '{44, 44, 44, 44, 40};

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u8 (
        .clk(clk), .rst(rst), .tx_dv(dv8), .tx_ready(ready8),
        .tx_data_in(data8), .cfg_parity(par8), .cfg_two_stop(two8),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk8),
`endif
        .tx_active(active8), .tx_data_out(line8), .tx_done(done8)
    );

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7)) u7 (
        .clk(clk), .rst(rst), .tx_dv(dv7), .tx_ready(ready7),
        .tx_data_in(data7), .cfg_parity(par7), .cfg_two_stop(two7),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk7),
`endif
        .tx_active(active7), .tx_data_out(line7), .tx_done(done7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected line level for bit period b of a frame.
    function automatic logic exp_bit(input logic [8:0] d, input int db,
                                     input bit pen, input logic pb, input int b);
        if (b == 0) return 1'b0;
        if (b <= db) return d[b-1];
        if (pen && b == db + 1) return pb;
        return 1'b1;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if (line8 !== 1'b1) begin
            errors++; $display("FAIL reset_line: got %b expected 1", line8);
        end
        checks++;
        if (active8 !== 1'b0 || done8 !== 1'b0) begin
            errors++; $display("FAIL reset_flags: active %b done %b expected 0 0", active8, done8);
        end
        checks++;
        if (ready8 !== 1'b0 || ready7 !== 1'b0) begin
            errors++; $display("FAIL reset_ready_in_rst: got %b %b expected 0 0", ready8, ready7);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ready8 !== 1'b1 || ready7 !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after: got %b %b expected 1 1", ready8, ready7);
        end
    endtask

    task automatic test_basic;
        int act, dn, done_at;
        logic e;
        dv8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            checks++;
            if (line8 !== 1'b1 || done8 !== 1'b0) begin
                errors++; $display("FAIL idle_hold: line %b done %b expected 1 0", line8, done8);
            end
        end
        data8 = 8'hA5; par8 = 2'b00; two8 = 1'b0; dv8 = 1'b1;
        checks++;
        if (ready8 !== 1'b1) begin
            errors++; $display("FAIL basic_ready: got %b expected 1", ready8);
        end
        tick;
        dv8 = 1'b0;
        act = 0; dn = 0; done_at = -1;
        for (int i = 1; i <= 45; i++) begin
            if (i <= 40) begin
                e = exp_bit({1'b0, 8'hA5}, 8, 1'b0, 1'b0, (i - 1) / 4);
                checks++;
                if (line8 !== e) begin
                    errors++; $display("FAIL basic_line c%0d: got %b expected %b", i, line8, e);
                end
            end
            if (active8 === 1'b1) act++;
            if (done8 === 1'b1) begin dn++; done_at = i; end
            tick;
        end
        checks++;
        if (act != 40) begin
            errors++; $display("FAIL basic_active_len: got %0d expected 40", act);
        end
        checks++;
        if (dn != 1 || done_at != 41) begin
            errors++; $display("FAIL basic_done: count %0d at %0d expected 1 at 41", dn, done_at);
        end
    endtask

    task automatic test_parity;
        int act, dn, done_at, n;
        bit pen;
        logic e;
        for (int v = 0; v < 5; v++) begin
            n = PV_LEN[v];
            pen = (PV_MODE[v] == 2'b01) || (PV_MODE[v] == 2'b10);
            data8 = PV_DATA[v]; par8 = PV_MODE[v]; two8 = 1'b0; dv8 = 1'b1;
            tick;
            dv8 = 1'b0;
            par8 = ~par8;
            data8 = ~data8;
            act = 0; dn = 0; done_at = -1;
            for (int i = 1; i <= n + 4; i++) begin
                if (i <= n) begin
                    e = exp_bit({1'b0, PV_DATA[v]}, 8, pen, PV_BIT[v], (i - 1) / 4);
                    checks++;
                    if (line8 !== e) begin
                        errors++;
                        $display("FAIL parity_line v%0d c%0d: got %b expected %b", v, i, line8, e);
                    end
                end
                if (active8 === 1'b1) act++;
                if (done8 === 1'b1) begin dn++; done_at = i; end
                tick;
            end
            checks++;
            if (act != n || dn != 1 || done_at != n + 1) begin
                errors++;
                $display("FAIL parity_len v%0d: active %0d done %0d at %0d expected %0d 1 at %0d",
                         v, act, dn, done_at, n, n + 1);
            end
        end
    endtask

    task automatic test_two_stop;
        int act, dn, done_at, n;
        logic [6:0] d;
        logic e;
        for (int v = 0; v < 2; v++) begin
            d = (v == 0) ? 7'h7F : 7'h2A;
            n = (v == 0) ? 40 : 36;
            data7 = d; par7 = 2'b00; two7 = (v == 0); dv7 = 1'b1;
            checks++;
            if (ready7 !== 1'b1) begin
                errors++; $display("FAIL two_stop_ready v%0d: got %b expected 1", v, ready7);
            end
            tick;
            dv7 = 1'b0;
            act = 0; dn = 0; done_at = -1;
            for (int i = 1; i <= n + 4; i++) begin
                if (i == 10) begin
                    two7 = ~two7;
                    data7 = 7'h00;
                end
                if (i <= n) begin
                    e = exp_bit({2'b00, d}, 7, 1'b0, 1'b0, (i - 1) / 4);
                    checks++;
                    if (line7 !== e) begin
                        errors++;
                        $display("FAIL two_stop_line v%0d c%0d: got %b expected %b", v, i, line7, e);
                    end
                end
                if (active7 === 1'b1) act++;
                if (done7 === 1'b1) begin dn++; done_at = i; end
                tick;
            end
            checks++;
            if (act != n || dn != 1 || done_at != n + 1) begin
                errors++;
                $display("FAIL two_stop_len v%0d: active %0d done %0d at %0d expected %0d 1 at %0d",
                         v, act, dn, done_at, n, n + 1);
            end
        end
    endtask

    task automatic test_back_to_back;
        int dn, d1, d2;
        logic e;
        data8 = 8'h55; par8 = 2'b00; two8 = 1'b0; dv8 = 1'b1;
        tick;
        data8 = 8'hAA;
        dn = 0; d1 = -1; d2 = -1;
        for (int i = 1; i <= 90; i++) begin
            if (i == 42) dv8 = 1'b0;
            if (i <= 40) e = exp_bit({1'b0, 8'h55}, 8, 1'b0, 1'b0, (i - 1) / 4);
            else if (i >= 42 && i <= 81) e = exp_bit({1'b0, 8'hAA}, 8, 1'b0, 1'b0, (i - 42) / 4);
            else e = 1'b1;
            checks++;
            if (line8 !== e) begin
                errors++; $display("FAIL b2b_line c%0d: got %b expected %b", i, line8, e);
            end
            if (i == 20 || i == 41) begin
                checks++;
                if (ready8 !== (i == 41)) begin
                    errors++;
                    $display("FAIL b2b_ready c%0d: got %b expected %b", i, ready8, i == 41);
                end
            end
            if (done8 === 1'b1) begin
                dn++;
                if (d1 < 0) d1 = i; else d2 = i;
            end
            tick;
        end
        checks++;
        if (dn != 2 || d1 != 41 || d2 != 82) begin
            errors++;
            $display("FAIL b2b_done: count %0d at %0d,%0d expected 2 at 41,82", dn, d1, d2);
        end
    endtask

    task automatic test_reset_mid;
        int dn, act;
        logic e;
        data8 = 8'hFF; par8 = 2'b01; two8 = 1'b1; dv8 = 1'b1;
        tick;
        dv8 = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            e = exp_bit({1'b0, 8'hFF}, 8, 1'b1, 1'b0, (i - 1) / 4);
            checks++;
            if (line8 !== e) begin
                errors++; $display("FAIL rstmid_line c%0d: got %b expected %b", i, line8, e);
            end
            if (i == 18) rst = 1'b1;
            tick;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (line8 !== 1'b1 || active8 !== 1'b0 || ready8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: line %b active %b ready %b done %b expected 1 0 1 0",
                     line8, active8, ready8, done8);
        end
        dn = 0;
        for (int i = 0; i < 50; i++) begin
            if (done8 === 1'b1 || line8 !== 1'b1) dn++;
            tick;
        end
        checks++;
        if (dn != 0) begin
            errors++; $display("FAIL rstmid_quiet: got %0d bad cycles expected 0", dn);
        end
        data8 = 8'h3C; par8 = 2'b00; two8 = 1'b0; dv8 = 1'b1;
        tick;
        dv8 = 1'b0;
        dn = 0; act = 0;
        for (int i = 1; i <= 42; i++) begin
            if (i <= 40) begin
                e = exp_bit({1'b0, 8'h3C}, 8, 1'b0, 1'b0, (i - 1) / 4);
                checks++;
                if (line8 !== e) begin
                    errors++; $display("FAIL rstmid_new c%0d: got %b expected %b", i, line8, e);
                end
            end
            if (active8 === 1'b1) act++;
            if (done8 === 1'b1) dn++;
            tick;
        end
        checks++;
        if (dn != 1 || act != 40) begin
            errors++; $display("FAIL rstmid_new_len: done %0d active %0d expected 1 40", dn, act);
        end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break;
        int bad;
        logic e;
        brk8 = 1'b1;
        bad = 0;
        for (int j = 1; j <= 20; j++) begin
            tick;
            if (j == 20) brk8 = 1'b0;
            if (line8 !== 1'b0 || ready8 !== 1'b0 || active8 !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL break_hold: got %0d bad cycles expected 0", bad);
        end
        tick;
        checks++;
        if (line8 !== 1'b1 || ready8 !== 1'b1 || active8 !== 1'b0) begin
            errors++;
            $display("FAIL break_release: line %b ready %b active %b expected 1 1 0",
                     line8, ready8, active8);
        end
        data8 = 8'hA5; par8 = 2'b00; two8 = 1'b0; dv8 = 1'b1;
        tick;
        dv8 = 1'b0;
        for (int i = 1; i <= 41; i++) begin
            if (i == 5) brk8 = 1'b1;
            e = (i <= 40) ? exp_bit({1'b0, 8'hA5}, 8, 1'b0, 1'b0, (i - 1) / 4) : 1'b1;
            checks++;
            if (line8 !== e) begin
                errors++; $display("FAIL break_frame c%0d: got %b expected %b", i, line8, e);
            end
            tick;
        end
        checks++;
        if (line8 !== 1'b0 || ready8 !== 1'b0) begin
            errors++; $display("FAIL break_after_done: line %b ready %b expected 0 0", line8, ready8);
        end
        brk8 = 1'b0;
        tick;
        checks++;
        if (line8 !== 1'b1 || ready8 !== 1'b1) begin
            errors++; $display("FAIL break_end: line %b ready %b expected 1 1", line8, ready8);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        dv8 = 1'b0; data8 = '0; par8 = '0; two8 = 1'b0; brk8 = 1'b0;
        dv7 = 1'b0; data7 = '0; par7 = '0; two7 = 1'b0; brk7 = 1'b0;
        test_reset;
        test_basic;
        test_parity;
        test_two_stop;
        test_back_to_back;
        test_reset_mid;
`ifdef UART_TX_BREAK_EN
        test_break;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter; successor to the fixed 8N1 transmitter.
- Serialises one frame per accepted word: start bit, DATA_BITS data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Uses a valid/ready handshake so an upstream FIFO or CPU register can stream frames back-to-back.
- Sits between the byte source and the TX pad.

Parameters:
CLKS_PER_BIT, 217, clk cycles per bit period; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
tx_dv  input  1  word valid; accepted on the same edge as tx_ready=1.
tx_ready  output  1  block can accept a word this cycle.
tx_data_in  input  DATA_BITS  word to send; bit 0 is sent first.
cfg_parity  input  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
cfg_two_stop  input  1  0 = one stop bit, 1 = two stop bits.
tx_active  output  1  high while a frame is on the line.
tx_data_out  output  1  serial line, registered; idle level 1.
tx_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: tx_data_out=1, tx_active=0, tx_done=0, state=IDLE, all counters 0. tx_ready=0 while rst=1.
- Outputs: all registered except tx_ready, which is (state==IDLE) && !rst.
- Accept: on a clk edge with tx_dv && tx_ready, latch tx_data_in, cfg_parity and cfg_two_stop. Config changes during a frame have no effect on that frame.
- Latency: start bit appears on tx_data_out in the cycle after accept.
- Bit timing: every bit holds for exactly CLKS_PER_BIT cycles.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Bit index: width $clog2(DATA_BITS); counts 0..DATA_BITS-1.
- States:
  - IDLE: line=1. Moves to START on accept.
  - START: line=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: line=data[idx] for CLKS_PER_BIT cycles. After the last bit, go to PARITY if parity is enabled, else STOP.
  - PARITY: line=parity bit. Even mode sends XOR of the data bits; odd mode sends its inverse.
  - STOP: line=1 for CLKS_PER_BIT cycles, or 2*CLKS_PER_BIT when two stop bits are latched.
  - After STOP, return to IDLE and pulse tx_done=1 for exactly that one IDLE cycle. tx_active falls in the same cycle.
- Frame length: 1+DATA_BITS+P+S bit periods, where P is 0/1 and S is 1/2.
- Back-to-back: tx_ready is high in the tx_done cycle. A word accepted then starts its start bit on the next cycle, so the only inter-frame gap is the stop bit(s).
- tx_dv low in IDLE: line stays 1 indefinitely and tx_done stays 0.
- tx_dv while busy: ignored (tx_ready=0). Data is not captured.
- Reset mid-frame: on the cycle after rst, line=1, tx_active=0, no tx_done pulse. The partial frame is abandoned.
- tx_active: rises the cycle after accept and stays high through the last stop-bit cycle.

Optional Feature:
Macro: UART_TX_BREAK_EN.
- Defined: adds input tx_break (1 bit).
  - Sampled only in IDLE. While tx_break=1 in IDLE, tx_data_out=0, tx_ready=0 and tx_active=1.
  - On release, the line returns to 1 the next cycle and tx_ready re-asserts.
  - tx_break asserted during a frame is ignored until that frame completes.
- Undefined: port absent; the line is driven only by frames.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, parity 00, one stop; send 0xA5.
   -> Line: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
   -> tx_done pulses once, 41 cycles after accept. tx_active is high for 40 cycles.
2. Same word with cfg_parity=01 -> parity bit 0, frame is 44 cycles. With cfg_parity=10 -> parity bit 1. Repeat with 0x01 -> even parity bit 1, odd parity bit 0.
3. cfg_two_stop=1, DATA_BITS=7, send 0x7F.
   -> Stop level held 8 cycles. Frame is 40 cycles.
   -> Toggling cfg_two_stop mid-frame does not change the frame.
4. tx_dv held high with 0x55 then 0xAA.
   -> Second start bit begins the cycle after the first tx_done. No idle-high gap beyond the stop bit. Exactly two tx_done pulses.
5. Assert rst for 1 cycle during the data bit 3 of 0xFF.
   -> Next cycle: line=1, tx_active=0, tx_ready=1, no tx_done.
   -> A new 0x3C accepted afterwards transmits correctly.
6. UART_TX_BREAK_EN defined: tx_break=1 for 20 cycles in IDLE.
   -> Line 0 and tx_ready 0 for 20 cycles, line 1 on the next cycle.
   -> tx_break raised mid-frame has no effect until the frame's tx_done.
